// File: rtl/con_port_arbiter.sv
// Round-robin arbiter sharing the core's data-memory controller port between two
// single-word requesters, with the memory read latency built into the sequence.
module con_port_arbiter #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 32,
  parameter int READ_LAT = 1
) (
  input  logic              CLK,
  input  logic              nrst,
  input  logic              r0_req,
  input  logic              r1_req,
  input  logic [3:0]        r0_we,
  input  logic [3:0]        r1_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r0_gnt,
  output logic              r1_gnt,
  output logic              r0_done,
  output logic              r1_done,
  output logic [DATA_W-1:0] r0_rdata,
  output logic [DATA_W-1:0] r1_rdata,
  output logic [ADDR_W-1:0] con_addr,
  output logic [3:0]        con_write,
  output logic [DATA_W-1:0] con_in,
  input  logic [DATA_W-1:0] con_out,
  output logic              busy
);
  localparam int NUM_REQ = 2;
  localparam int CNT_W   = 3;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t                         state, state_nxt;
  logic [NUM_REQ-1:0]             req, gnt, done;
  logic [NUM_REQ-1:0][3:0]        we;
  logic [NUM_REQ-1:0][ADDR_W-1:0] addr;
  logic [NUM_REQ-1:0][DATA_W-1:0] wdata, rdata;
  logic                           sel, last_gnt, win;
  logic [CNT_W-1:0]               cnt;

  assign req   = {r1_req, r0_req};
  assign we    = {r1_we, r0_we};
  assign addr  = {r1_addr, r0_addr};
  assign wdata = {r1_wdata, r0_wdata};

  assign {r1_gnt, r0_gnt}   = gnt;
  assign {r1_done, r0_done} = done;
  assign r0_rdata           = rdata[0];
  assign r1_rdata           = rdata[1];

  // On a tie the requester not served last wins; otherwise the lone requester.
  always_comb begin
    win = req[1];
    if (&req) win = ~last_gnt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req) state_nxt = ISSUE;
      ISSUE:   state_nxt = (con_write != '0) ? DONE : WAIT;
      WAIT:    if (cnt == CNT_W'(1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nrst) state <= IDLE;
    else       state <= state_nxt;
  end

  // con_write is the latched byte enable only during ISSUE, so it doubles as the
  // write/read flag for the ISSUE decision.
  always_ff @(posedge CLK) begin
    if (!nrst) begin
      con_write <= '0;
      con_addr  <= '0;
      con_in    <= '0;
      gnt       <= '0;
      done      <= '0;
      rdata     <= '0;
      busy      <= 1'b0;
      last_gnt  <= 1'b1;
      sel       <= 1'b0;
      cnt       <= '0;
    end else begin
      con_write <= '0;
      done      <= '0;
      busy      <= (state_nxt != IDLE);
      case (state)
        IDLE: if (|req) begin
          sel       <= win;
          last_gnt  <= win;
          gnt[win]  <= 1'b1;
          con_write <= we[win];
          con_addr  <= addr[win];
          con_in    <= wdata[win];
        end
        ISSUE: begin
          if (con_write != '0) done[sel] <= 1'b1;
          else                 cnt       <= CNT_W'(READ_LAT);
        end
        WAIT: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            rdata[sel] <= con_out;
            done[sel]  <= 1'b1;
          end
        end
        DONE:    gnt <= '0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_con_port_arbiter.sv
// Bench for con_port_arbiter: directed scenarios plus a randomized run checked
// against a transaction-timeline model of the arbiter.
module tb_con_port_arbiter;
  logic        CLK = 1'b0;
  logic        nrst = 1'b0;
  int          cyc = 0;
  int          npass = 0, ntot = 0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // main DUT, READ_LAT = 1
  logic        r0_req = 0, r1_req = 0;
  logic [3:0]  r0_we = 0, r1_we = 0;
  logic [9:0]  r0_addr = 0, r1_addr = 0;
  logic [31:0] r0_wdata = 0, r1_wdata = 0;
  logic        r0_gnt, r1_gnt, r0_done, r1_done, busy;
  logic [31:0] r0_rdata, r1_rdata, con_in, con_out;
  logic [9:0]  con_addr;
  logic [3:0]  con_write;

  // second DUT, READ_LAT = 3
  logic        t0_req = 0, t1_req = 0;
  logic [3:0]  t0_we = 0, t1_we = 0;
  logic [9:0]  t0_addr = 0, t1_addr = 0;
  logic [31:0] t0_wdata = 0, t1_wdata = 0;
  logic        t0_gnt, t1_gnt, t0_done, t1_done, t_busy;
  logic [31:0] t0_rdata, t1_rdata, t_con_in, t_con_out;
  logic [9:0]  t_con_addr;
  logic [3:0]  t_con_write;

  function automatic logic [31:0] mem_word(input logic [9:0] a);
    if (a == 10'h3FF) return 32'h12345678;
    return {a, 22'h0} ^ (32'h9E3779B9 * {22'h0, a});
  endfunction

  // memory with one cycle of read latency; second DUT sees a per-cycle value
  always @(posedge CLK) con_out <= mem_word(con_addr);
  assign t_con_out = 32'hC0DE0000 + 32'(cyc);

  con_port_arbiter #(.ADDR_W(10), .DATA_W(32), .READ_LAT(1)) u_dut (
    .CLK(CLK), .nrst(nrst),
    .r0_req(r0_req), .r1_req(r1_req), .r0_we(r0_we), .r1_we(r1_we),
    .r0_addr(r0_addr), .r1_addr(r1_addr), .r0_wdata(r0_wdata), .r1_wdata(r1_wdata),
    .r0_gnt(r0_gnt), .r1_gnt(r1_gnt), .r0_done(r0_done), .r1_done(r1_done),
    .r0_rdata(r0_rdata), .r1_rdata(r1_rdata),
    .con_addr(con_addr), .con_write(con_write), .con_in(con_in), .con_out(con_out),
    .busy(busy));

  con_port_arbiter #(.ADDR_W(10), .DATA_W(32), .READ_LAT(3)) u_dut3 (
    .CLK(CLK), .nrst(nrst),
    .r0_req(t0_req), .r1_req(t1_req), .r0_we(t0_we), .r1_we(t1_we),
    .r0_addr(t0_addr), .r1_addr(t1_addr), .r0_wdata(t0_wdata), .r1_wdata(t1_wdata),
    .r0_gnt(t0_gnt), .r1_gnt(t1_gnt), .r0_done(t0_done), .r1_done(t1_done),
    .r0_rdata(t0_rdata), .r1_rdata(t1_rdata),
    .con_addr(t_con_addr), .con_write(t_con_write), .con_in(t_con_in), .con_out(t_con_out),
    .busy(t_busy));

  task automatic do_reset;
    nrst = 1'b0; r0_req = 0; r1_req = 0; t0_req = 0; t1_req = 0;
    repeat (2) @(negedge CLK);
    nrst = 1'b1;
  endtask

  task automatic test_reset;
    nrst = 1'b0; r0_req = 1; r1_req = 1; t0_req = 1;
    repeat (2) @(negedge CLK);
    ntot++; if ({r0_gnt, r1_gnt, r0_done, r1_done, busy} !== 5'b0)
      $display("FAIL rst_ctrl: got %b want 00000", {r0_gnt, r1_gnt, r0_done, r1_done, busy}); else npass++;
    ntot++; if (con_write !== 4'h0) $display("FAIL rst_con_write: got %h want 0", con_write); else npass++;
    ntot++; if (con_addr !== 10'h0) $display("FAIL rst_con_addr: got %h want 0", con_addr); else npass++;
    ntot++; if (con_in !== 32'h0) $display("FAIL rst_con_in: got %h want 0", con_in); else npass++;
    ntot++; if ({r0_rdata, r1_rdata} !== 64'h0) $display("FAIL rst_rdata: got %h want 0", {r0_rdata, r1_rdata}); else npass++;
    ntot++; if ({t_busy, t0_gnt} !== 2'b0) $display("FAIL rst_dut3: got %b want 00", {t_busy, t0_gnt}); else npass++;
    r0_req = 0; r1_req = 0; t0_req = 0;
    nrst = 1'b1;
  endtask

  task automatic test_write_r0;
    do_reset();
    r0_req = 1; r0_we = 4'hF; r0_addr = 10'h010; r0_wdata = 32'hDEADBEEF;
    @(negedge CLK);
    ntot++; if (con_write !== 4'hF) $display("FAIL wr_con_write: got %h want f", con_write); else npass++;
    ntot++; if (con_addr !== 10'h010) $display("FAIL wr_con_addr: got %h want 010", con_addr); else npass++;
    ntot++; if (con_in !== 32'hDEADBEEF) $display("FAIL wr_con_in: got %h want deadbeef", con_in); else npass++;
    ntot++; if ({r0_gnt, r0_done, busy} !== 3'b101) $display("FAIL wr_gnt_r1: got %b want 101", {r0_gnt, r0_done, busy}); else npass++;
    @(negedge CLK);
    ntot++; if (con_write !== 4'h0) $display("FAIL wr_cw_r2: got %h want 0", con_write); else npass++;
    ntot++; if ({r0_gnt, r0_done} !== 2'b11) $display("FAIL wr_done_r2: got %b want 11", {r0_gnt, r0_done}); else npass++;
    r0_req = 0;
    @(negedge CLK);
    ntot++; if ({r0_gnt, r0_done, busy} !== 3'b0) $display("FAIL wr_end_r3: got %b want 000", {r0_gnt, r0_done, busy}); else npass++;
    ntot++; if ({r1_gnt, r1_done, r1_rdata} !== 34'h0) $display("FAIL wr_r1_untouched: got %h want 0", {r1_gnt, r1_done, r1_rdata}); else npass++;
  endtask

  task automatic test_read_r1;
    int nw = 0;
    r1_req = 1; r1_we = 4'h0; r1_addr = 10'h3FF; r1_wdata = 32'h55AA55AA;
    for (int k = 1; k <= 4; k++) begin
      @(negedge CLK);
      if (con_write !== 4'h0) nw++;
      if (k == 1) begin
        ntot++; if ({r1_gnt, con_addr} !== {1'b1, 10'h3FF}) $display("FAIL rd_gnt_addr: got %b/%h want 1/3ff", r1_gnt, con_addr); else npass++;
      end
      if (k == 2) begin
        ntot++; if (r1_done !== 1'b0) $display("FAIL rd_early_done: got %b want 0", r1_done); else npass++;
      end
      if (k == 3) begin
        ntot++; if (r1_done !== 1'b1) $display("FAIL rd_done_r3: got %b want 1", r1_done); else npass++;
        ntot++; if (r1_rdata !== 32'h12345678) $display("FAIL rd_data: got %h want 12345678", r1_rdata); else npass++;
        r1_req = 0;
      end
      if (k == 4) begin
        ntot++; if ({r1_done, r1_rdata} !== {1'b0, 32'h12345678}) $display("FAIL rd_hold: got %b/%h want 0/12345678", r1_done, r1_rdata); else npass++;
        ntot++; if (r0_rdata !== 32'h0) $display("FAIL rd_r0_untouched: got %h want 0", r0_rdata); else npass++;
      end
    end
    ntot++; if (nw != 0) $display("FAIL rd_con_write: got %0d write cycles want 0", nw); else npass++;
  endtask

  task automatic test_persistent;
    int dcyc[$];
    int dwho[$];
    int r, ov = 0;
    do_reset();
    r = cyc;
    r0_req = 1; r0_we = 0; r0_addr = 10'h001;
    r1_req = 1; r1_we = 0; r1_addr = 10'h002;
    repeat (20) begin
      @(negedge CLK);
      if (r0_gnt && r1_gnt) ov++;
      if (r0_done) begin dcyc.push_back(cyc); dwho.push_back(0); end
      if (r1_done) begin dcyc.push_back(cyc); dwho.push_back(1); end
    end
    r0_req = 0; r1_req = 0;
    ntot++; if (ov != 0) $display("FAIL pers_overlap: got %0d cycles want 0", ov); else npass++;
    ntot++; if (dcyc.size() != 5) $display("FAIL pers_count: got %0d want 5", dcyc.size()); else npass++;
    for (int i = 0; i < dcyc.size(); i++) begin
      ntot++; if (dwho[i] != i % 2) $display("FAIL pers_order[%0d]: got r%0d want r%0d", i, dwho[i], i % 2); else npass++;
      ntot++; if (dcyc[i] - ((i == 0) ? r : dcyc[i-1]) != ((i == 0) ? 3 : 4))
        $display("FAIL pers_spacing[%0d]: got %0d want %0d", i, dcyc[i] - ((i == 0) ? r : dcyc[i-1]), (i == 0) ? 3 : 4); else npass++;
    end
    ntot++; if ({r0_rdata, r1_rdata} !== {mem_word(10'h001), mem_word(10'h002)})
      $display("FAIL pers_rdata: got %h/%h want %h/%h", r0_rdata, r1_rdata, mem_word(10'h001), mem_word(10'h002)); else npass++;
    repeat (3) @(negedge CLK);
  endtask

  task automatic test_reset_mid_read;
    r0_req = 1; r0_we = 0; r0_addr = 10'h020;
    repeat (2) @(negedge CLK);
    ntot++; if ({busy, r0_gnt, r0_done} !== 3'b110) $display("FAIL mid_wait: got %b want 110", {busy, r0_gnt, r0_done}); else npass++;
    nrst = 1'b0; r0_req = 0;
    @(negedge CLK);
    ntot++; if ({r0_gnt, r1_gnt, r0_done, r1_done, busy} !== 5'b0)
      $display("FAIL mid_ctrl: got %b want 00000", {r0_gnt, r1_gnt, r0_done, r1_done, busy}); else npass++;
    ntot++; if ({con_write, con_addr, con_in} !== 46'h0) $display("FAIL mid_con: got %h/%h/%h want 0", con_write, con_addr, con_in); else npass++;
    ntot++; if ({r0_rdata, r1_rdata} !== 64'h0) $display("FAIL mid_rdata: got %h want 0", {r0_rdata, r1_rdata}); else npass++;
    nrst = 1'b1;
    r1_req = 1; r1_we = 0; r1_addr = 10'h155;
    @(negedge CLK);
    ntot++; if ({r1_gnt, r0_gnt} !== 2'b10) $display("FAIL mid_regrant: got %b want 10", {r1_gnt, r0_gnt}); else npass++;
    repeat (2) @(negedge CLK);
    ntot++; if ({r1_done, r0_done} !== 2'b10) $display("FAIL mid_redone: got %b want 10", {r1_done, r0_done}); else npass++;
    ntot++; if (r1_rdata !== mem_word(10'h155)) $display("FAIL mid_redata: got %h want %h", r1_rdata, mem_word(10'h155)); else npass++;
    r1_req = 0;
    @(negedge CLK);
  endtask

  task automatic test_lat3;
    int r = cyc;
    int nw = 0;
    t0_req = 1; t0_we = 0; t0_addr = 10'h0AA;
    for (int k = 1; k <= 6; k++) begin
      @(negedge CLK);
      if (t_con_write !== 4'h0) nw++;
      if (k == 1) begin
        t0_req = 0; t0_addr = 10'h155; t0_we = 4'hF;
      end
      if (k == 3) begin
        ntot++; if (t_con_addr !== 10'h0AA) $display("FAIL lat3_addr_held: got %h want 0aa", t_con_addr); else npass++;
      end
      if (k == 4) begin
        ntot++; if (t0_done !== 1'b0) $display("FAIL lat3_early_done: got %b want 0", t0_done); else npass++;
      end
      if (k == 5) begin
        ntot++; if ({t0_done, t0_gnt} !== 2'b11) $display("FAIL lat3_done: got %b want 11", {t0_done, t0_gnt}); else npass++;
        ntot++; if (t0_rdata !== 32'hC0DE0000 + 32'(r + 4))
          $display("FAIL lat3_data: got %h want %h", t0_rdata, 32'hC0DE0000 + 32'(r + 4)); else npass++;
      end
      if (k == 6) begin
        ntot++; if ({t0_done, t0_gnt, t_busy} !== 3'b0) $display("FAIL lat3_end: got %b want 000", {t0_done, t0_gnt, t_busy}); else npass++;
      end
    end
    t0_we = 0;
    ntot++; if (nw != 0) $display("FAIL lat3_con_write: got %0d write cycles want 0", nw); else npass++;
  endtask

  task automatic test_drop_req;
    int nw = 0;
    r0_req = 1; r0_we = 4'h3; r0_addr = 10'h0F0; r0_wdata = $urandom;
    @(posedge CLK);
    #1 r0_req = 0; r0_we = 4'hC; r0_addr = 10'h0F1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge CLK);
      if (con_write !== 4'h0) nw++;
      if (k == 1) begin
        ntot++; if ({con_write, con_addr} !== {4'h3, 10'h0F0}) $display("FAIL drop_issue: got %h/%h want 3/0f0", con_write, con_addr); else npass++;
      end
      if (k == 2) begin
        ntot++; if ({r0_done, r0_gnt} !== 2'b11) $display("FAIL drop_done: got %b want 11", {r0_done, r0_gnt}); else npass++;
      end
      if (k == 4) begin
        ntot++; if ({r0_done, r0_gnt, busy} !== 3'b0) $display("FAIL drop_no_repeat: got %b want 000", {r0_done, r0_gnt, busy}); else npass++;
      end
    end
    r0_we = 0;
    ntot++; if (nw != 1) $display("FAIL drop_write_once: got %0d write cycles want 1", nw); else npass++;
  endtask

  // Timeline model: when the port is free and someone requests at cycle R,
  // the winner owns the port R+1..D with D = R+2 (write) or R+3 (read).
  task automatic test_random;
    logic [3:0]  s_we[2];
    logic [9:0]  s_addr[2];
    logic [31:0] s_wd[2];
    logic [31:0] mrd[2];
    bit          s_req[2];
    bit          pend[2];
    bit          act = 0;
    int          mR = 0, mD = 0, mfree, mwho = 0, mlast = 1, c, w;
    logic [3:0]  mwe = 0;
    logic [9:0]  maddr = 0;
    logic [31:0] mwd = 0;
    logic [1:0]  eg, ed;
    logic [3:0]  ecw;
    logic        eb;
    for (int i = 0; i < 2; i++) begin
      s_we[i] = 0; s_addr[i] = 0; s_wd[i] = 0; mrd[i] = 0; s_req[i] = 0; pend[i] = 0;
    end
    do_reset();
    mfree = cyc;
    repeat (600) begin
      c = cyc;
      if (act && c == mD && mwe == 4'h0) mrd[mwho] = mem_word(maddr);
      eg = '0; ed = '0; ecw = '0; eb = 1'b0;
      if (act && c > mR && c <= mD) begin eg[mwho] = 1'b1; eb = 1'b1; end
      if (act && c == mD) ed[mwho] = 1'b1;
      if (act && c == mR + 1) ecw = mwe;
      ntot++; if ({r1_gnt, r0_gnt} !== eg) $display("FAIL rnd_gnt @%0d: got %b want %b", c, {r1_gnt, r0_gnt}, eg); else npass++;
      ntot++; if ({r1_done, r0_done} !== ed) $display("FAIL rnd_done @%0d: got %b want %b", c, {r1_done, r0_done}, ed); else npass++;
      ntot++; if (con_write !== ecw) $display("FAIL rnd_con_write @%0d: got %h want %h", c, con_write, ecw); else npass++;
      ntot++; if (busy !== eb) $display("FAIL rnd_busy @%0d: got %b want %b", c, busy, eb); else npass++;
      ntot++; if (con_addr !== maddr) $display("FAIL rnd_con_addr @%0d: got %h want %h", c, con_addr, maddr); else npass++;
      ntot++; if (con_in !== mwd) $display("FAIL rnd_con_in @%0d: got %h want %h", c, con_in, mwd); else npass++;
      ntot++; if (r0_rdata !== mrd[0]) $display("FAIL rnd_r0_rdata @%0d: got %h want %h", c, r0_rdata, mrd[0]); else npass++;
      ntot++; if (r1_rdata !== mrd[1]) $display("FAIL rnd_r1_rdata @%0d: got %h want %h", c, r1_rdata, mrd[1]); else npass++;
      // new requests from idle requesters
      for (int i = 0; i < 2; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1; s_req[i] = 1;
          s_we[i] = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
          s_addr[i] = 10'($urandom); s_wd[i] = $urandom;
        end
      end
      // the granted requester scribbles on its fields after grant
      if (act && c > mR && c < mD) begin
        s_req[mwho] = 1'($urandom); s_we[mwho] = 4'($urandom);
        s_addr[mwho] = 10'($urandom); s_wd[mwho] = $urandom;
      end
      if (act && c == mD) begin
        act = 0; pend[mwho] = 0; s_req[mwho] = 0; mfree = c + 1;
      end
      if (!act && c >= mfree && (s_req[0] || s_req[1])) begin
        w = (s_req[0] && s_req[1]) ? 1 - mlast : (s_req[1] ? 1 : 0);
        act = 1; mR = c; mwho = w; mlast = w;
        mwe = s_we[w]; maddr = s_addr[w]; mwd = s_wd[w];
        mD = c + ((mwe != 4'h0) ? 2 : 3);
      end
      r0_req = s_req[0]; r0_we = s_we[0]; r0_addr = s_addr[0]; r0_wdata = s_wd[0];
      r1_req = s_req[1]; r1_we = s_we[1]; r1_addr = s_addr[1]; r1_wdata = s_wd[1];
      @(negedge CLK);
    end
    r0_req = 0; r1_req = 0;
  endtask

  initial begin
    @(negedge CLK);
    test_reset();
    test_write_r0();
    test_read_r1();
    test_persistent();
    test_reset_mid_read();
    test_lat3();
    test_drop_req();
    test_random();
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
